// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and helpers for the memory-access stage
package mem_stage_pkg;

    // funct3 access size/sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] carries the access size independent of signedness
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte-lane mask for an access of the given size at the given byte offset
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001 << off;
            SZ_H:    m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// rtl/mem_stage_load_extend.sv - lane select and sign/zero extension of load data
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half from the raw word, then extend by funct3
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with handshaked data-memory port
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic                   i_mem_read,
    input  logic                   i_mem_write,
    input  logic [2:0]             i_funct3,
    input  logic [31:0]            i_addr,
    input  logic [31:0]            i_store_data,
    output logic                   o_dmem_req,
    output logic                   o_dmem_wen,
    output logic                   o_dmem_ren,
    output logic [31:0]            o_dmem_addr,
    output logic [3:0]             o_dmem_mask,
    output logic [31:0]            o_dmem_wdata,
    input  logic                   i_dmem_ready,
    input  logic                   i_dmem_rvalid,
    input  logic [31:0]            i_dmem_rdata,
    output logic                   o_stall,
    output logic                   o_valid,
    output logic [31:0]            o_load_data,
    output logic [31:0]            o_dmem_rdata,
    output logic                   o_misaligned,
    output logic [STALL_CNT_W-1:0] o_stall_cycles
);

    state_t           state;
    state_t           state_nxt;
    logic             mem_op;
    logic             is_store;
    logic             misaligned;
    logic             complete;
    logic [31:0]      ext_data;
    logic [STALL_CNT_W-1:0] stall_cnt;

    assign mem_op   = i_valid & (i_mem_read | i_mem_write);
    assign is_store = i_mem_write;

    // Request address/mask/data follow the frozen EX/MEM inputs, so they stay stable in REQ
    always_comb begin
        o_dmem_addr = {i_addr[31:2], 2'b00};
        o_dmem_mask = lane_mask(i_funct3[1:0], i_addr[1:0]);
        case (i_funct3[1:0])
            SZ_B:    o_dmem_wdata = {24'd0, i_store_data[7:0]}  << {i_addr[1:0], 3'b000};
            SZ_H:    o_dmem_wdata = {16'd0, i_store_data[15:0]} << {i_addr[1:0], 3'b000};
            default: o_dmem_wdata = i_store_data;
        endcase
        case (i_funct3[1:0])
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = i_addr[0];
            default: misaligned = |i_addr[1:0];
        endcase
    end

    mem_stage_load_extend u_load_extend (
        .rdata     (i_dmem_rdata),
        .addr_lo   (i_addr[1:0]),
        .funct3    (i_funct3),
        .load_data (ext_data)
    );

    // Next-state and handshake outputs; reset forces everything quiet
    always_comb begin
        state_nxt    = state;
        o_dmem_req   = 1'b0;
        o_stall      = 1'b0;
        o_valid      = 1'b0;
        o_misaligned = 1'b0;
        complete     = 1'b0;
        if (!i_rst) begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        if (misaligned) begin
                            o_misaligned = 1'b1;
                            o_valid      = 1'b1;
                        end else begin
                            o_dmem_req = 1'b1;
                            if (i_dmem_ready && is_store) begin
                                o_valid = 1'b1;
                            end else if (i_dmem_ready) begin
                                state_nxt = ST_RESP;
                                o_stall   = 1'b1;
                            end else begin
                                state_nxt = ST_REQ;
                                o_stall   = 1'b1;
                            end
                        end
                    end else begin
                        o_valid = i_valid;
                    end
                end
                ST_REQ: begin
                    o_dmem_req = 1'b1;
                    o_stall    = 1'b1;
                    if (i_dmem_ready) begin
                        if (is_store) begin
                            o_stall   = 1'b0;
                            o_valid   = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    o_stall = 1'b1;
                    if (i_dmem_rvalid) begin
                        o_stall   = 1'b0;
                        o_valid   = 1'b1;
                        complete  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign o_dmem_wen   = o_dmem_req & is_store;
    assign o_dmem_ren   = o_dmem_req & ~is_store;
    assign o_load_data  = complete ? ext_data : 32'd0;
    assign o_dmem_rdata = complete ? i_dmem_rdata : 32'd0;
    assign o_stall_cycles = stall_cnt;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (o_stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        dmem_ready = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;

    logic        dmem_req, dmem_wen, dmem_ren;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_mask;
    logic        stall, out_valid, misaligned;
    logic [31:0] load_data, rdata_out;
    logic [15:0] stall_cycles;

    logic        s_req, s_wen, s_ren, s_stall, s_valid, s_mis;
    logic [31:0] s_addr, s_wdata, s_load, s_rdata;
    logic [3:0]  s_mask;
    logic [1:0]  s_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_stage #(.STALL_CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_mem_read(mem_read),
        .i_mem_write(mem_write), .i_funct3(funct3), .i_addr(addr),
        .i_store_data(store_data), .o_dmem_req(dmem_req), .o_dmem_wen(dmem_wen),
        .o_dmem_ren(dmem_ren), .o_dmem_addr(dmem_addr), .o_dmem_mask(dmem_mask),
        .o_dmem_wdata(dmem_wdata), .i_dmem_ready(dmem_ready), .i_dmem_rvalid(dmem_rvalid),
        .i_dmem_rdata(dmem_rdata), .o_stall(stall), .o_valid(out_valid),
        .o_load_data(load_data), .o_dmem_rdata(rdata_out), .o_misaligned(misaligned),
        .o_stall_cycles(stall_cycles)
    );

    mem_stage #(.STALL_CNT_W(2)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_mem_read(mem_read),
        .i_mem_write(mem_write), .i_funct3(funct3), .i_addr(addr),
        .i_store_data(store_data), .o_dmem_req(s_req), .o_dmem_wen(s_wen),
        .o_dmem_ren(s_ren), .o_dmem_addr(s_addr), .o_dmem_mask(s_mask),
        .o_dmem_wdata(s_wdata), .i_dmem_ready(dmem_ready), .i_dmem_rvalid(dmem_rvalid),
        .i_dmem_rdata(dmem_rdata), .o_stall(s_stall), .o_valid(s_valid),
        .o_load_data(s_load), .o_dmem_rdata(s_rdata), .o_misaligned(s_mis),
        .o_stall_cycles(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        valid = v; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    endtask

    // Load accepted at issue, response one cycle later
    task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] rd, input logic [31:0] exp);
        drive(1'b1, 1'b1, 1'b0, f3, a, 32'd0);
        dmem_ready = 1'b1;
        tick;
        dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd;
        settle;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, load_data, exp);
        tick;
        idle;
    endtask

    initial begin
        idle;
        rst = 1'b1;
        tick;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
        dmem_ready = 1'b1;
        settle;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);
        tick;
        chk("rst_cnt", 32'(stall_cycles), 32'd0);
        rst = 1'b0;
        idle;
        tick;

        // LW 0x100, accepted at issue, rvalid two cycles later
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
        dmem_ready = 1'b1;
        settle;
        chk("lw_req", 32'(dmem_req), 32'd1);
        chk("lw_ren", 32'(dmem_ren), 32'd1);
        chk("lw_addr", dmem_addr, 32'h100);
        chk("lw_mask", 32'(dmem_mask), 32'hF);
        chk("lw_stall0", 32'(stall), 32'd1);
        chk("lw_valid0", 32'(out_valid), 32'd0);
        tick;
        dmem_ready = 1'b0;
        settle;
        chk("lw_stall1", 32'(stall), 32'd1);
        chk("lw_req1", 32'(dmem_req), 32'd0);
        tick;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        settle;
        chk("lw_valid", 32'(out_valid), 32'd1);
        chk("lw_stall2", 32'(stall), 32'd0);
        chk("lw_data", load_data, 32'hDEADBEEF);
        chk("lw_raw", rdata_out, 32'hDEADBEEF);
        tick;
        idle;
        settle;
        chk("lw_cnt", 32'(stall_cycles), 32'd2);
        chk("raw_idle", rdata_out, 32'd0);

        // SB 0x203, ready after three stalled cycles
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5);
        settle;
        chk("sb_addr", dmem_addr, 32'h200);
        chk("sb_mask", 32'(dmem_mask), 32'b1000);
        chk("sb_wdata", dmem_wdata, 32'hA5000000);
        chk("sb_wen", 32'(dmem_wen), 32'd1);
        chk("sb_stall0", 32'(stall), 32'd1);
        tick;
        tick;
        settle;
        chk("sb_req2", 32'(dmem_req), 32'd1);
        chk("sb_stall2", 32'(stall), 32'd1);
        chk("sb_wdata2", dmem_wdata, 32'hA5000000);
        tick;
        dmem_ready = 1'b1;
        settle;
        chk("sb_valid", 32'(out_valid), 32'd1);
        chk("sb_stall3", 32'(stall), 32'd0);
        tick;
        idle;
        settle;
        chk("sb_cnt", 32'(stall_cycles), 32'd5);

        // Load extraction cases
        quick_load("lh", 3'b001, 32'h02, 32'h80010000, 32'hFFFF8001);
        quick_load("lhu", 3'b101, 32'h02, 32'h80010000, 32'h00008001);
        quick_load("lbu", 3'b100, 32'h01, 32'h00007F00, 32'h0000007F);
        quick_load("lb", 3'b000, 32'h03, 32'h80123456, 32'hFFFFFF80);

        // Misaligned word load
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h102, 32'd0);
        dmem_ready = 1'b1;
        settle;
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_flag", 32'(misaligned), 32'd1);
        chk("mis_valid", 32'(out_valid), 32'd1);
        chk("mis_stall", 32'(stall), 32'd0);
        chk("mis_data", load_data, 32'd0);
        tick;
        // Misaligned half store
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h101, 32'h1234);
        settle;
        chk("mish_req", 32'(dmem_req), 32'd0);
        chk("mish_flag", 32'(misaligned), 32'd1);
        tick;
        idle;

        // Reset while waiting in RESP, stale rvalid afterwards
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'd0);
        dmem_ready = 1'b1;
        tick;
        dmem_ready = 1'b0;
        settle;
        chk("rr_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        idle;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA55AA;
        settle;
        chk("rr_valid", 32'(out_valid), 32'd0);
        chk("rr_stall2", 32'(stall), 32'd0);
        chk("rr_data", load_data, 32'd0);
        tick;
        idle;
        settle;
        chk("rr_cnt", 32'(stall_cycles), 32'd0);

        // ALU op then SW accepted at issue: no bubbles
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h77, 32'd0);
        settle;
        chk("alu_valid", 32'(out_valid), 32'd1);
        chk("alu_stall", 32'(stall), 32'd0);
        chk("alu_req", 32'(dmem_req), 32'd0);
        tick;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h300, 32'h12345678);
        dmem_ready = 1'b1;
        settle;
        chk("sw_valid", 32'(out_valid), 32'd1);
        chk("sw_stall", 32'(stall), 32'd0);
        chk("sw_req", 32'(dmem_req), 32'd1);
        chk("sw_wdata", dmem_wdata, 32'h12345678);
        tick;
        idle;
        settle;
        chk("sw_cnt", 32'(stall_cycles), 32'd0);

        // Five-cycle wait saturates the 2-bit counter
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) tick;
        dmem_ready = 1'b1;
        settle;
        chk("sat_valid", 32'(out_valid), 32'd1);
        tick;
        idle;
        settle;
        chk("sat_cnt2", 32'(s_cnt), 32'd3);
        chk("sat_cnt16", 32'(stall_cycles), 32'd5);

        // rvalid in IDLE is ignored
        dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
        settle;
        chk("idle_rv_valid", 32'(out_valid), 32'd0);
        chk("idle_rv_raw", rdata_out, 32'd0);
        tick;
        idle;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
